// File: rtl/alu_mul_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer_pkg
// Shared definitions for the multiply sequencer and its neighbours in EXE:
//   - ALU command encodings (as understood by the existing single-cycle ALU)
//   - {N,Z,C,V} flag bit indices
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package alu_mul_sequencer_pkg;

  localparam logic [3:0] ALU_CMD_NOP = 4'b0000;
  localparam logic [3:0] ALU_CMD_MOV = 4'b0001;
  localparam logic [3:0] ALU_CMD_ADD = 4'b0010;
  localparam logic [3:0] ALU_CMD_ADC = 4'b0011;
  localparam logic [3:0] ALU_CMD_SUB = 4'b0100;
  localparam logic [3:0] ALU_CMD_SBC = 4'b0101;
  localparam logic [3:0] ALU_CMD_AND = 4'b0110;
  localparam logic [3:0] ALU_CMD_ORR = 4'b0111;
  localparam logic [3:0] ALU_CMD_EOR = 4'b1000;
  localparam logic [3:0] ALU_CMD_MVN = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer_if
// Bundle between the EXE stage / ALU and the multiply sequencer.
//   master : EXE-stage side (drives request, operands, status, ALU result)
//   slave  : sequencer side (drives ALU operands/command, busy/done/result)
// Optional: ALU_MUL_SEQ_MLA_EN adds acc_in and mla (multiply-accumulate).
// ---------------------------------------------------------------------------
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             s_bit;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       status_in;
  logic [WIDTH-1:0] alu_result;
`ifdef ALU_MUL_SEQ_MLA_EN
  logic [WIDTH-1:0] acc_in;
  logic             mla;
`endif
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [3:0]       alu_exe_cmd;
  logic             alu_carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       status_out;
  logic             flags_we;

  modport master (
    output start, s_bit, op_a, op_b, status_in, alu_result,
`ifdef ALU_MUL_SEQ_MLA_EN
    output acc_in, mla,
`endif
    input  alu_in1, alu_in2, alu_exe_cmd, alu_carry_in,
    input  busy, done, result, status_out, flags_we
  );

  modport slave (
    input  start, s_bit, op_a, op_b, status_in, alu_result,
`ifdef ALU_MUL_SEQ_MLA_EN
    input  acc_in, mla,
`endif
    output alu_in1, alu_in2, alu_exe_cmd, alu_carry_in,
    output busy, done, result, status_out, flags_we
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer
// Runs MUL (low WIDTH bits of WIDTH x WIDTH product) on the existing ALU by
// shift-add: one ALU ADD per cycle for WIDTH cycles, then a one-cycle DONE.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : alu_mul_sequencer_if.slave
//              in : start, s_bit, op_a (Rm), op_b (Rs), status_in, alu_result
//              out: alu_in1, alu_in2, alu_exe_cmd, alu_carry_in, busy, done,
//                   result, status_out, flags_we
// Optional feature macro: ALU_MUL_SEQ_MLA_EN (acc_in/mla -> Rm*Rs+Rn).
// ---------------------------------------------------------------------------
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_mul_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  seq_state_t       state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             s_bit_reg;
  logic             c_reg;
  logic             v_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] acc_init;

`ifdef ALU_MUL_SEQ_MLA_EN
  assign acc_init = bus.mla ? bus.acc_in : '0;
`else
  assign acc_init = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      s_bit_reg  <= 1'b0;
      c_reg      <= 1'b0;
      v_reg      <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            mcand_reg  <= bus.op_a;
            mplier_reg <= bus.op_b;
            s_bit_reg  <= bus.s_bit;
            c_reg      <= bus.status_in[FLAG_C];
            v_reg      <= bus.status_in[FLAG_V];
            acc_reg    <= acc_init;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The ALU has added the gated multiplicand into acc this cycle.
          acc_reg    <= bus.alu_result;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          // start seen here is deliberately dropped, not queued.
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  logic running;
  assign running = (state_reg == ST_RUN);

  // ALU drive depends only on state and internal registers, never on start.
  assign bus.alu_exe_cmd  = running ? ALU_CMD_ADD : ALU_CMD_NOP;
  assign bus.alu_in1      = running ? acc_reg : '0;
  assign bus.alu_in2      = (running && mplier_reg[0]) ? mcand_reg : '0;
  assign bus.alu_carry_in = 1'b0;

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.result     = done_reg ? acc_reg : '0;
  // C and V pass through untouched, as ARM MULS does.
  assign bus.status_out = done_reg ? {acc_reg[WIDTH-1], (acc_reg == '0), c_reg, v_reg} : 4'b0000;
  assign bus.flags_we   = done_reg & s_bit_reg;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_sequencer
// Drives the sequencer next to a behavioural ALU and compares every product
// against plain 64-bit multiplication truncated to 32 bits.
// ---------------------------------------------------------------------------
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   check_cnt;
  int   pass_cnt;

  alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the EXE-stage ALU.
  function automatic logic [31:0] alu_model(input logic [3:0] cmd, input logic [31:0] a,
                                             input logic [31:0] b, input logic cin);
    case (cmd)
      ALU_CMD_MOV: return b;
      ALU_CMD_ADD: return a + b;
      ALU_CMD_ADC: return a + b + {31'd0, cin};
      ALU_CMD_SUB: return a - b;
      ALU_CMD_AND: return a & b;
      ALU_CMD_ORR: return a | b;
      ALU_CMD_EOR: return a ^ b;
      ALU_CMD_MVN: return ~b;
      default:     return 32'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_exe_cmd, bus.alu_in1, bus.alu_in2, bus.alu_carry_in);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      pass_cnt++;
  endtask

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.s_bit     = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.status_in = 4'b0000;
`ifdef ALU_MUL_SEQ_MLA_EN
    bus.acc_in    = '0;
    bus.mla       = 1'b0;
`endif
  endtask

  // One full multiply, checked end to end.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [3:0] st, input logic [31:0] ain, input logic m);
    logic [63:0] full;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
    int          n;
    full    = {32'd0, a} * {32'd0, b};
    exp_res = full[31:0];
`ifdef ALU_MUL_SEQ_MLA_EN
    if (m) exp_res = exp_res + ain;
`else
    if (m && ain != 0) ; // accumulate inputs only exist in the MLA build
`endif
    exp_st = {exp_res[31], (exp_res == 32'd0), st[1], st[0]};

    @(negedge clk);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.s_bit = s; bus.status_in = st;
`ifdef ALU_MUL_SEQ_MLA_EN
    bus.acc_in = ain; bus.mla = m;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    check("cmd_in_run", {28'd0, bus.alu_exe_cmd}, {28'd0, ALU_CMD_ADD});
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'd32);
    check("result", bus.result, exp_res);
    check("status_out", {28'd0, bus.status_out}, {28'd0, exp_st});
    check("flags_we", {31'd0, bus.flags_we}, {31'd0, s});
    check("carry_in", {31'd0, bus.alu_carry_in}, 32'd0);
    $display("op a=%h b=%h s=%0d st=%b -> result=%h status=%b flags_we=%0d (exp %h %b)",
             a, b, s, st, bus.result, bus.status_out, bus.flags_we, exp_res, exp_st);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("idle_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dones;
    int          n;
    logic [31:0] first_res;
    check_cnt = 0;
    pass_cnt  = 0;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_cmd", {28'd0, bus.alu_exe_cmd}, {28'd0, ALU_CMD_NOP});
    check("rst_result", bus.result, 32'd0);
    check("rst_in1", bus.alu_in1, 32'd0);
    check("rst_in2", bus.alu_in2, 32'd0);
    check("rst_status", {28'd0, bus.status_out}, 32'd0);
    check("rst_flags_we", {31'd0, bus.flags_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(32'd3, 32'd5, 1'b1, 4'b0011, 32'd0, 1'b0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'b1010, 32'd0, 1'b0);
    run_op(32'h00010000, 32'h00010000, 1'b1, 4'b0000, 32'd0, 1'b0);
    run_op(32'h80000000, 32'd1, 1'b1, 4'b0110, 32'd0, 1'b0);
    run_op(32'd0, 32'h12345678, 1'b1, 4'b1111, 32'd0, 1'b0);

    // start held through the whole operation with new operands after capture
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd6; bus.op_b = 32'd11; bus.s_bit = 1'b0;
    @(posedge clk); #1;
    bus.op_a = 32'd7; bus.op_b = 32'd9;
    dones = 0;
    first_res = 32'd0;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        first_res = bus.result;
      end
    end
    check("held_done_count", 32'(dones), 32'd1);
    check("held_first_result", first_res, 32'd66);
    check("held_idle_gap", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    check("held_restart", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_second_result", bus.result, 32'd63);
    $display("held-start: done pulses=%0d first=%0d second=%0d", dones, first_res, bus.result);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd123; bus.op_b = 32'd456;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_cmd", {28'd0, bus.alu_exe_cmd}, {28'd0, ALU_CMD_NOP});
    check("arst_in1", bus.alu_in1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("arst_no_done", 32'(dones), 32'd0);
    $display("abort: done pulses after reset=%0d", dones);
    run_op(32'd2, 32'd2, 1'b1, 4'b0000, 32'd0, 1'b0);

`ifdef ALU_MUL_SEQ_MLA_EN
    run_op(32'd3, 32'd4, 1'b1, 4'b0000, 32'd5, 1'b1);
    run_op(32'd3, 32'd4, 1'b1, 4'b0000, 32'd5, 1'b0);
`endif

    // Randomized operations
    for (int i = 0; i < 20; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
